unidad_busqueda: RTL and testbench
==================================

UNIDAD_BUSQUEDA -- requirements
Module: unidad_busqueda

Interface
REQ-001 Parameter NBITS, default 32, datapath/PC width.
REQ-002 Parameter CELDAS, default 60, instruction-memory size in byte-addressed cells; legal PCs are 0..CELDAS-4.
REQ-003 Parameter HALT_WORD, default 32'hFFFF_FFFF, instruction encoding that stops fetch.
REQ-004 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 i_reset_n  input  1  reset, asynchronous and active-low.
REQ-006 i_instruction  input  NBITS  word returned by the instruction memory, one cycle after o_PC.
REQ-007 i_stall  input  1  hazard stall from decode; hold fetch.
REQ-008 i_jump  input  1  jump resolved in decode.
REQ-009 i_jump_target  input  NBITS  jump destination byte address.
REQ-010 i_branch_taken  input  1  taken branch resolved in execute.
REQ-011 i_branch_target  input  NBITS  branch destination byte address.
REQ-012 i_debug_mode  input  1  1 = step mode; PC advances only on i_step.
REQ-013 i_step  input  1  single-cycle step pulse, honoured only when i_debug_mode=1.
REQ-014 o_PC  output  NBITS  address driven to the instruction memory.
REQ-015 o_PC4  output  NBITS  PC+4 of the instruction currently on i_instruction.
REQ-016 o_valid  output  1  i_instruction is a live instruction for IF/ID.
REQ-017 o_halt  output  1  fetch stopped (halt word or error).
REQ-018 o_error  output  1  PC left legal range.

Function
REQ-019 The block SHALL implement a 3-state FSM: PRIME, RUN, HALT.
REQ-020 PRIME SHALL last exactly one cycle after reset release with o_PC=0, o_valid=0, then go to RUN.
REQ-021 In RUN, an "advance" SHALL occur when (i_debug_mode=0 or i_step=1) and i_stall=0.
REQ-022 Next-PC priority in RUN: i_branch_taken > i_jump > advance (o_PC+4) > hold.
REQ-023 Redirect (branch or jump) SHALL override i_stall and step gating, load the target into o_PC next cycle, and force o_valid=0 in the following cycle (in-flight flush).
REQ-024 Latency: o_PC=A at cycle t SHALL yield o_valid=1 and o_PC4=A+4 at t+1, aligned with i_instruction=mem[A].
REQ-025 On a held cycle (stall or no step), o_PC and o_PC4 SHALL be unchanged and o_valid SHALL retain its value.
REQ-026 PC arithmetic SHALL be NBITS-bit unsigned, incrementing by 4; no wrap to 0.
REQ-027 If the next PC (sequential or redirect) exceeds CELDAS-4 or is not a multiple of 4, the block SHALL enter HALT with o_error=1, o_PC held.
REQ-028 If o_valid=1 and i_instruction==HALT_WORD, the block SHALL enter HALT next cycle, o_valid=0, o_PC held.
REQ-029 A halt word arriving in the same cycle as a redirect SHALL be ignored (flushed); the redirect wins.
REQ-030 HALT SHALL be absorbing: o_halt=1, o_valid=0, all inputs ignored until reset.

Reset
REQ-031 Assertion of i_reset_n=0 SHALL immediately, without clock, force o_PC=0, o_PC4=0, o_valid=0, o_halt=0, o_error=0, state PRIME.
REQ-032 Reset mid-operation (any state, including during a redirect or stall) SHALL discard all in-flight state identically.

Structure
REQ-033 FSM state encodings, HALT_WORD and PC increment constant (4) SHALL live in the shared MIPS package.
REQ-034 The next-PC selection SHALL be a sub-module named mux_pc; the FSM and registers stay in unidad_busqueda.

Verification
REQ-035 Reset release, no hazards, mem returns NOP -> o_PC 0,0,4,8,12; o_valid 0,0,1,1; o_PC4 4,8 aligned.
REQ-036 i_stall=1 for 2 cycles at o_PC=16 -> o_PC stays 16, o_PC4 stays 16, then resumes 20.
REQ-037 i_branch_taken=1, target 52, together with i_stall=1 and i_jump=1 (target 20) at o_PC=32 -> o_PC=52 next cycle, o_valid=0 for one cycle, then o_PC4=56 valid.
REQ-038 i_instruction=32'hFFFF_FFFF with o_valid=1 -> o_halt=1, o_valid=0 next cycle; toggling i_step/i_jump afterwards leaves o_PC unchanged.
REQ-039 i_debug_mode=1, three i_step pulses spaced 5 cycles -> o_PC 0->4->8->12 only on pulse cycles; jump to 58 -> o_error=1, o_halt=1.
REQ-040 i_reset_n pulsed low asynchronously mid-RUN at o_PC=24 -> outputs zero before next edge, PRIME then fetch from 0.

Source files
------------

// File: rtl/unidad_busqueda_pkg.sv
// Shared fetch-stage definitions: FSM encoding, halt instruction word, and PC increment.
package unidad_busqueda_pkg;

    typedef enum logic [1:0] {
        ST_PRIME = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam int unsigned PC_INC            = 4;

endpackage

// File: rtl/unidad_busqueda_mux_pc.sv
// Next-PC selection for the fetch stage: branch > jump > sequential > hold,
// plus a legality flag for any PC that would actually be loaded.
module mux_pc
    import unidad_busqueda_pkg::*;
#(
    parameter int NBITS  = 32,
    parameter int CELDAS = 60
) (
    input  logic [NBITS-1:0] pc,
    input  logic             branch_taken,
    input  logic [NBITS-1:0] branch_target,
    input  logic             jump,
    input  logic [NBITS-1:0] jump_target,
    input  logic             advance,
    output logic [NBITS-1:0] next_pc,
    output logic             redirect,
    output logic             move,
    output logic             illegal
);

    // One extra bit so a sequential increment past the top of the range is seen, not wrapped.
    localparam logic [NBITS:0] PC_MAX = (NBITS+1)'(CELDAS) - (NBITS+1)'(PC_INC);

    logic [NBITS:0] cand;

    always_comb begin
        redirect = branch_taken | jump;
        move     = redirect | advance;
        if (branch_taken) begin
            cand = {1'b0, branch_target};
        end else if (jump) begin
            cand = {1'b0, jump_target};
        end else if (advance) begin
            cand = {1'b0, pc} + (NBITS+1)'(PC_INC);
        end else begin
            cand = {1'b0, pc};
        end
        next_pc = cand[NBITS-1:0];
        illegal = move && ((cand > PC_MAX) || (cand[1:0] != 2'b00));
    end

endmodule

// File: rtl/unidad_busqueda.sv
// Instruction fetch unit: PRIME/RUN/HALT FSM owning the PC, PC+4 and valid registers.
module unidad_busqueda
    import unidad_busqueda_pkg::*;
#(
    parameter int               NBITS     = 32,
    parameter int               CELDAS    = 60,
    parameter logic [NBITS-1:0] HALT_WORD = NBITS'(HALT_WORD_DEFAULT)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [NBITS-1:0] i_instruction,
    input  logic             i_stall,
    input  logic             i_jump,
    input  logic [NBITS-1:0] i_jump_target,
    input  logic             i_branch_taken,
    input  logic [NBITS-1:0] i_branch_target,
    input  logic             i_debug_mode,
    input  logic             i_step,
    output logic [NBITS-1:0] o_PC,
    output logic [NBITS-1:0] o_PC4,
    output logic             o_valid,
    output logic             o_halt,
    output logic             o_error,
    output fetch_state_t     fsm_state
);

    // Handshake: o_valid qualifies i_instruction/o_PC4 for IF/ID; there is no ready,
    // back-pressure arrives as i_stall, which freezes PC, PC4 and o_valid.
    fetch_state_t     state_q, state_next;
    logic [NBITS-1:0] pc_q, pc_next, pc4_q, pc4_next, mux_next;
    logic             valid_q, valid_next, error_q, error_next;
    logic             advance, redirect, move, illegal, halt_seen;

    assign advance = (~i_debug_mode | i_step) & ~i_stall;

    mux_pc #(
        .NBITS  (NBITS),
        .CELDAS (CELDAS)
    ) u_mux_pc (
        .pc            (pc_q),
        .branch_taken  (i_branch_taken),
        .branch_target (i_branch_target),
        .jump          (i_jump),
        .jump_target   (i_jump_target),
        .advance       (advance),
        .next_pc       (mux_next),
        .redirect      (redirect),
        .move          (move),
        .illegal       (illegal)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_PRIME;
            pc_q    <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_next;
            pc_q    <= pc_next;
            pc4_q   <= pc4_next;
            valid_q <= valid_next;
            error_q <= error_next;
        end
    end

    always_comb begin
        state_next = state_q;
        pc_next    = pc_q;
        pc4_next   = pc4_q;
        valid_next = valid_q;
        error_next = error_q;
        halt_seen  = valid_q && (i_instruction == HALT_WORD);
        unique case (state_q)
            ST_PRIME: begin
                state_next = ST_RUN;
                valid_next = 1'b0;
            end
            ST_RUN: begin
                // A redirect flushes a halt word that is still in flight.
                if (move && (redirect || !halt_seen)) begin
                    if (illegal) begin
                        state_next = ST_HALT;
                        error_next = 1'b1;
                        valid_next = 1'b0;
                    end else if (redirect) begin
                        pc_next    = mux_next;
                        valid_next = 1'b0;
                    end else begin
                        pc_next    = mux_next;
                        pc4_next   = mux_next;
                        valid_next = 1'b1;
                    end
                end else if (halt_seen) begin
                    state_next = ST_HALT;
                    valid_next = 1'b0;
                end
            end
            ST_HALT: begin
                valid_next = 1'b0;
            end
            default: begin
                state_next = ST_PRIME;
                valid_next = 1'b0;
            end
        endcase
    end

    assign o_PC      = pc_q;
    assign o_PC4     = pc4_q;
    assign o_valid   = valid_q;
    assign o_error   = error_q;
    assign o_halt    = (state_q == ST_HALT);
    assign fsm_state = state_q;

endmodule

// File: tb/tb_unidad_busqueda.sv
// Self-checking bench for unidad_busqueda with a registered instruction-memory model.
module tb_unidad_busqueda;
  import unidad_busqueda_pkg::*;

  logic         i_clk, i_reset_n;
  logic [31:0]  i_instruction;
  logic         i_stall, i_jump, i_branch_taken, i_debug_mode, i_step;
  logic [31:0]  i_jump_target, i_branch_target;
  logic [31:0]  o_PC, o_PC4;
  logic         o_valid, o_halt, o_error;
  fetch_state_t fsm_state;

  logic [31:0]  mem [0:15];
  logic [66:0]  exp_q[$];
  logic [66:0]  msk_q[$];
  logic [66:0]  exp_v, msk_v, got_v;
  int           vectors, miscompares;

  localparam logic [66:0] FULL   = {67{1'b1}};
  localparam logic [66:0] NO_PC4 = {3'b111, 32'h0, 32'hFFFF_FFFF};

  unidad_busqueda dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_instruction   (i_instruction),
    .i_stall         (i_stall),
    .i_jump          (i_jump),
    .i_jump_target   (i_jump_target),
    .i_branch_taken  (i_branch_taken),
    .i_branch_target (i_branch_target),
    .i_debug_mode    (i_debug_mode),
    .i_step          (i_step),
    .o_PC            (o_PC),
    .o_PC4           (o_PC4),
    .o_valid         (o_valid),
    .o_halt          (o_halt),
    .o_error         (o_error),
    .fsm_state       (fsm_state)
  );

  // clock / reset block
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) i_instruction <= mem[o_PC[5:2]];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_stall = 1'b0; i_jump = 1'b0; i_jump_target = '0;
    i_branch_taken = 1'b0; i_branch_target = '0;
    i_debug_mode = 1'b0; i_step = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    i_reset_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] pc4, input logic v,
                          input logic h, input logic e, input logic [66:0] m);
    exp_q.push_back({h, e, v, pc4, pc});
    msk_q.push_back(m);
  endtask

  function automatic logic [66:0] observed();
    return {o_halt, o_error, o_valid, o_PC4, o_PC};
  endfunction

  task automatic test_reset();
    clear_inputs();
    i_reset_n = 1'b1;
    #2;
    i_reset_n = 1'b0;
    #1;
    push_exp(0, 0, 0, 0, 0, FULL);
    push_exp(0, 0, 0, 0, 0, FULL);
    for (int c = 0; c < 2; c++) begin
      if (c > 0) tick();
      exp_v = exp_q.pop_front(); msk_v = msk_q.pop_front(); got_v = observed();
      vectors++;
      if ((got_v & msk_v) !== (exp_v & msk_v)) begin
        miscompares++;
        $display("FAIL reset c%0d: got pc=%0d pc4=%0d v=%0b h=%0b e=%0b, expected pc=%0d pc4=%0d v=%0b h=%0b e=%0b",
                 c, got_v[31:0], got_v[63:32], got_v[64], got_v[66], got_v[65],
                 exp_v[31:0], exp_v[63:32], exp_v[64], exp_v[66], exp_v[65]);
      end
      vectors++;
      if (fsm_state !== ST_PRIME) begin
        miscompares++;
        $display("FAIL reset_state c%0d: got %0d expected %0d", c, fsm_state, ST_PRIME);
      end
    end
    i_reset_n = 1'b1;
  endtask

  task automatic test_fetch();
    logic [31:0] pcs [5];
    pcs = '{0, 0, 4, 8, 12};
    for (int c = 0; c < 5; c++) push_exp(pcs[c], pcs[c], c >= 2, 0, 0, FULL);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      exp_v = exp_q.pop_front(); msk_v = msk_q.pop_front(); got_v = observed();
      vectors++;
      if ((got_v & msk_v) !== (exp_v & msk_v)) begin
        miscompares++;
        $display("FAIL fetch c%0d: got pc=%0d pc4=%0d v=%0b h=%0b e=%0b, expected pc=%0d pc4=%0d v=%0b h=%0b e=%0b",
                 c, got_v[31:0], got_v[63:32], got_v[64], got_v[66], got_v[65],
                 exp_v[31:0], exp_v[63:32], exp_v[64], exp_v[66], exp_v[65]);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] pcs [4];
    pcs = '{16, 16, 16, 20};
    for (int c = 0; c < 4; c++) push_exp(pcs[c], pcs[c], 1, 0, 0, FULL);
    for (int c = 0; c < 4; c++) begin
      tick();
      exp_v = exp_q.pop_front(); msk_v = msk_q.pop_front(); got_v = observed();
      vectors++;
      if ((got_v & msk_v) !== (exp_v & msk_v)) begin
        miscompares++;
        $display("FAIL stall c%0d: got pc=%0d pc4=%0d v=%0b h=%0b e=%0b, expected pc=%0d pc4=%0d v=%0b h=%0b e=%0b",
                 c, got_v[31:0], got_v[63:32], got_v[64], got_v[66], got_v[65],
                 exp_v[31:0], exp_v[63:32], exp_v[64], exp_v[66], exp_v[65]);
      end
      i_stall = (c < 2);
    end
  endtask

  task automatic test_redirect();
    push_exp(24, 24, 1, 0, 0, FULL);
    push_exp(28, 28, 1, 0, 0, FULL);
    push_exp(32, 32, 1, 0, 0, FULL);
    push_exp(52, 0, 0, 0, 0, NO_PC4);
    push_exp(56, 56, 1, 0, 0, FULL);
    push_exp(56, 0, 0, 1, 1, NO_PC4);
    push_exp(56, 0, 0, 1, 1, NO_PC4);
    for (int c = 0; c < 7; c++) begin
      tick();
      exp_v = exp_q.pop_front(); msk_v = msk_q.pop_front(); got_v = observed();
      vectors++;
      if ((got_v & msk_v) !== (exp_v & msk_v)) begin
        miscompares++;
        $display("FAIL redirect c%0d: got pc=%0d pc4=%0d v=%0b h=%0b e=%0b, expected pc=%0d pc4=%0d v=%0b h=%0b e=%0b",
                 c, got_v[31:0], got_v[63:32], got_v[64], got_v[66], got_v[65],
                 exp_v[31:0], exp_v[63:32], exp_v[64], exp_v[66], exp_v[65]);
      end
      if (c == 2) begin
        i_branch_taken = 1'b1; i_branch_target = 52;
        i_jump = 1'b1; i_jump_target = 20; i_stall = 1'b1;
      end else begin
        clear_inputs();
      end
    end
  endtask

  task automatic test_halt_word();
    logic [31:0] pcs [5];
    pcs = '{0, 0, 4, 8, 12};
    mem[2] = HALT_WORD_DEFAULT;
    apply_reset();
    for (int c = 0; c < 5; c++) push_exp(pcs[c], pcs[c], c >= 2, 0, 0, FULL);
    for (int c = 0; c < 4; c++) push_exp(12, 0, 0, 1, 0, NO_PC4);
    for (int c = 0; c < 9; c++) begin
      if (c > 0) tick();
      exp_v = exp_q.pop_front(); msk_v = msk_q.pop_front(); got_v = observed();
      vectors++;
      if ((got_v & msk_v) !== (exp_v & msk_v)) begin
        miscompares++;
        $display("FAIL halt_word c%0d: got pc=%0d pc4=%0d v=%0b h=%0b e=%0b, expected pc=%0d pc4=%0d v=%0b h=%0b e=%0b",
                 c, got_v[31:0], got_v[63:32], got_v[64], got_v[66], got_v[65],
                 exp_v[31:0], exp_v[63:32], exp_v[64], exp_v[66], exp_v[65]);
      end
      if (c >= 5) begin
        i_debug_mode = 1'b1;
        i_step = (c % 2 == 1);
        i_jump = (c % 2 == 1);
        i_jump_target = $urandom_range(0, 13) * 4;
      end
    end
    mem[2] = 32'h0;
    clear_inputs();
  endtask

  task automatic test_jump_flush();
    logic [31:0] pcs [5];
    pcs = '{0, 0, 4, 8, 12};
    mem[2] = HALT_WORD_DEFAULT;
    apply_reset();
    for (int c = 0; c < 5; c++) push_exp(pcs[c], pcs[c], c >= 2, 0, 0, FULL);
    push_exp(40, 0, 0, 0, 0, NO_PC4);
    push_exp(44, 44, 1, 0, 0, FULL);
    push_exp(44, 0, 0, 1, 1, NO_PC4);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      exp_v = exp_q.pop_front(); msk_v = msk_q.pop_front(); got_v = observed();
      vectors++;
      if ((got_v & msk_v) !== (exp_v & msk_v)) begin
        miscompares++;
        $display("FAIL jump_flush c%0d: got pc=%0d pc4=%0d v=%0b h=%0b e=%0b, expected pc=%0d pc4=%0d v=%0b h=%0b e=%0b",
                 c, got_v[31:0], got_v[63:32], got_v[64], got_v[66], got_v[65],
                 exp_v[31:0], exp_v[63:32], exp_v[64], exp_v[66], exp_v[65]);
      end
      i_jump = (c == 4) || (c == 6);
      i_jump_target = (c == 4) ? 32'd40 : 32'd22;
    end
    mem[2] = 32'h0;
    clear_inputs();
  endtask

  task automatic test_debug_step();
    logic [31:0] pc;
    apply_reset();
    i_debug_mode = 1'b1;
    for (int c = 0; c < 16; c++) begin
      pc = (c < 4) ? 0 : (c < 9) ? 4 : (c < 14) ? 8 : 12;
      push_exp(pc, pc, c >= 4, 0, 0, FULL);
    end
    push_exp(12, 0, 0, 1, 1, NO_PC4);
    for (int c = 0; c < 17; c++) begin
      if (c > 0) tick();
      exp_v = exp_q.pop_front(); msk_v = msk_q.pop_front(); got_v = observed();
      vectors++;
      if ((got_v & msk_v) !== (exp_v & msk_v)) begin
        miscompares++;
        $display("FAIL debug_step c%0d: got pc=%0d pc4=%0d v=%0b h=%0b e=%0b, expected pc=%0d pc4=%0d v=%0b h=%0b e=%0b",
                 c, got_v[31:0], got_v[63:32], got_v[64], got_v[66], got_v[65],
                 exp_v[31:0], exp_v[63:32], exp_v[64], exp_v[66], exp_v[65]);
      end
      i_step = (c == 3) || (c == 8) || (c == 13);
      i_jump = (c == 15);
      i_jump_target = 32'd58;
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    logic [31:0] pcs [8];
    pcs = '{0, 0, 4, 8, 12, 16, 20, 24};
    apply_reset();
    for (int c = 0; c < 8; c++) push_exp(pcs[c], pcs[c], c >= 2, 0, 0, FULL);
    push_exp(0, 0, 0, 0, 0, FULL);
    push_exp(0, 0, 0, 0, 0, FULL);
    push_exp(0, 0, 0, 0, 0, FULL);
    push_exp(4, 4, 1, 0, 0, FULL);
    for (int c = 0; c < 12; c++) begin
      if (c == 8) begin
        #2;
        i_reset_n = 1'b0;
        #1;
        vectors++;
        if (fsm_state !== ST_PRIME) begin
          miscompares++;
          $display("FAIL async_reset_state: got %0d expected %0d", fsm_state, ST_PRIME);
        end
      end else if (c == 9) begin
        tick();
        i_reset_n = 1'b1;
      end else if (c > 0) begin
        tick();
      end
      exp_v = exp_q.pop_front(); msk_v = msk_q.pop_front(); got_v = observed();
      vectors++;
      if ((got_v & msk_v) !== (exp_v & msk_v)) begin
        miscompares++;
        $display("FAIL async_reset c%0d: got pc=%0d pc4=%0d v=%0b h=%0b e=%0b, expected pc=%0d pc4=%0d v=%0b h=%0b e=%0b",
                 c, got_v[31:0], got_v[63:32], got_v[64], got_v[66], got_v[65],
                 exp_v[31:0], exp_v[63:32], exp_v[64], exp_v[66], exp_v[65]);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_halt_word();
    test_jump_flush();
    test_debug_step();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
